smoothing_filter_param: RTL and testbench

Parametrised streaming moving-average (box) smoothing filter for the edge-detection pixel path. It replaces the fixed 8-bit smoothing stage with configurable sample width and power-of-two window depth. It adds a valid handshake, a synchronous clear, selectable rounding and a selectable warm-up policy. It sits between the pixel source and the gradient stage.

---
 rtl/smoothing_filter_param.sv | 103 ++++++++++
 tb/tb_smoothing_filter_param.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/smoothing_filter_param.sv
// Streaming box filter: N-tap moving average over a circular buffer with a running sum.
// Registered output, optional round-half-up, optional suppression of output until the window fills.
module smoothing_filter_param #(
    parameter int DATA_W          = 8,
    parameter int LOG2_DEPTH      = 2,
    parameter bit ROUND           = 1'b1,
    parameter bit HOLD_UNTIL_FULL = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enb,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              win_full
);
    localparam int N     = 1 << LOG2_DEPTH;
    localparam int SUM_W = DATA_W + LOG2_DEPTH;
    localparam int CNT_W = LOG2_DEPTH + 1;
    localparam logic [DATA_W:0] MAX_OUT = {1'b0, {DATA_W{1'b1}}};
    localparam logic [SUM_W:0]  RND_ADD = ROUND ? (SUM_W+1)'(N/2) : '0;

    typedef enum logic {FILL, RUN} state_e;

    state_e                       state_q, state_d;
    logic [N-1:0][DATA_W-1:0]     buf_q, buf_d;
    logic [LOG2_DEPTH-1:0]        wr_ptr_q, wr_ptr_d;
    logic [SUM_W-1:0]             sum_q, sum_d;
    logic [CNT_W-1:0]             fill_cnt_q, fill_cnt_d;
    logic                         out_valid_q, out_valid_d;
    logic [DATA_W-1:0]            out_data_q, out_data_d;

    logic                         acc, emit;
    logic [SUM_W-1:0]             sum_upd;
    logic [SUM_W:0]               rnd;
    logic [DATA_W:0]              avg;

    always_comb begin
        acc     = enb && in_valid && !clear;
        // sum always holds the oldest entry, so subtracting it cannot wrap
        sum_upd = sum_q + SUM_W'(in_data) - SUM_W'(buf_q[wr_ptr_q]);
        rnd     = {1'b0, sum_upd} + RND_ADD;
        avg     = (DATA_W+1)'(rnd >> LOG2_DEPTH);
        emit    = acc && (!HOLD_UNTIL_FULL || state_q == RUN ||
                          fill_cnt_q == CNT_W'(N-1));

        state_d     = state_q;
        buf_d       = buf_q;
        wr_ptr_d    = wr_ptr_q;
        sum_d       = sum_q;
        fill_cnt_d  = fill_cnt_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;

        if (enb && clear) begin
            state_d    = FILL;
            buf_d      = '0;
            wr_ptr_d   = '0;
            sum_d      = '0;
            fill_cnt_d = '0;
            out_data_d = '0;
        end else if (acc) begin
            buf_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + LOG2_DEPTH'(1);
            sum_d           = sum_upd;
            if (state_q == FILL) begin
                fill_cnt_d = fill_cnt_q + CNT_W'(1);
                if (fill_cnt_q == CNT_W'(N-1)) state_d = RUN;
            end
            if (emit) begin
                out_valid_d = 1'b1;
                out_data_d  = (avg > MAX_OUT) ? MAX_OUT[DATA_W-1:0] : avg[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FILL;
            buf_q       <= '0;
            wr_ptr_q    <= '0;
            sum_q       <= '0;
            fill_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            wr_ptr_q    <= wr_ptr_d;
            sum_q       <= sum_d;
            fill_cnt_q  <= fill_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign win_full  = (state_q == RUN);

endmodule

// File: tb/tb_smoothing_filter_param.sv
// Directed bench: three filter variants (round/zero-pad, round/hold, truncate/hold) share one stimulus.
module tb_smoothing_filter_param;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enb = 1'b0, clear = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = '0;

    logic       ov_a, wf_a, ov_h, wf_h, ov_t, wf_t;
    logic [7:0] od_a, od_h, od_t;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    smoothing_filter_param #(.DATA_W(8), .LOG2_DEPTH(2), .ROUND(1'b1), .HOLD_UNTIL_FULL(1'b0)) u_dut (
        .clk(clk), .reset(reset), .enb(enb), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov_a), .out_data(od_a), .win_full(wf_a));

    smoothing_filter_param #(.DATA_W(8), .LOG2_DEPTH(2), .ROUND(1'b1), .HOLD_UNTIL_FULL(1'b1)) u_hold (
        .clk(clk), .reset(reset), .enb(enb), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov_h), .out_data(od_h), .win_full(wf_h));

    smoothing_filter_param #(.DATA_W(8), .LOG2_DEPTH(2), .ROUND(1'b0), .HOLD_UNTIL_FULL(1'b1)) u_trunc (
        .clk(clk), .reset(reset), .enb(enb), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov_t), .out_data(od_t), .win_full(wf_t));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic c, input logic v, input logic [7:0] d);
        enb = e; clear = c; in_valid = v; in_data = d;
        @(posedge clk); #1;
    endtask

    task automatic rst_pulse();
        reset = 1'b0; #2; reset = 1'b1;
    endtask

    int s1_in [6] = '{4, 5, 6, 7, 8, 9};
    int s1_a  [6] = '{1, 2, 4, 6, 7, 8};
    int s1_wf [6] = '{0, 0, 0, 1, 1, 1};
    int s1_hv [6] = '{0, 0, 0, 1, 1, 1};
    int s1_hd [6] = '{0, 0, 0, 6, 7, 8};
    int s1_td [6] = '{0, 0, 0, 5, 6, 7};
    int s3_a  [4] = '{64, 128, 191, 255};
    int s4_a  [4] = '{3, 5, 8, 10};
    int s5_a  [4] = '{2, 4, 6, 8};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov", ov_a, 0);
        chk("rst_od", od_a, 0);
        chk("rst_wf", wf_a, 0);
        reset = 1'b1;

        // ramp-in stream on all three variants
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 1, 8'(s1_in[i]));
            chk($sformatf("s1_ov_%0d", i), ov_a, 1);
            chk($sformatf("s1_od_%0d", i), od_a, s1_a[i]);
            chk($sformatf("s1_wf_%0d", i), wf_a, s1_wf[i]);
            chk($sformatf("s1_hov_%0d", i), ov_h, s1_hv[i]);
            chk($sformatf("s1_hod_%0d", i), od_h, s1_hd[i]);
            chk($sformatf("s1_tov_%0d", i), ov_t, s1_hv[i]);
            chk($sformatf("s1_tod_%0d", i), od_t, s1_td[i]);
        end
        cyc(1, 0, 0, 0);
        chk("s1_idle_ov", ov_a, 0);
        chk("s1_idle_od", od_a, 8);

        // full-scale samples
        rst_pulse();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 1, 8'd255);
            chk($sformatf("s3_od_%0d", i), od_a, s3_a[i]);
        end
        chk("s3_wf", wf_a, 1);
        cyc(1, 0, 1, 8'd0);
        chk("s3_od_drop", od_a, 191);

        // asynchronous reset mid-window
        rst_pulse();
        cyc(1, 0, 1, 8'd4);
        chk("s4_od0", od_a, 1);
        cyc(1, 0, 1, 8'd5);
        chk("s4_od1", od_a, 2);
        #2; reset = 1'b0; #1;
        chk("s4_async_ov", ov_a, 0);
        chk("s4_async_od", od_a, 0);
        chk("s4_async_wf", wf_a, 0);
        #1; reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 1, 8'd10);
            chk($sformatf("s4_od_%0d", i), od_a, s4_a[i]);
        end
        chk("s4_wf", wf_a, 1);

        // clear beats a simultaneous sample
        rst_pulse();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 1, 8'd8);
            chk($sformatf("s5_od_%0d", i), od_a, s5_a[i]);
        end
        chk("s5_wf_full", wf_a, 1);
        cyc(1, 1, 1, 8'd200);
        chk("s5_clr_ov", ov_a, 0);
        chk("s5_clr_od", od_a, 0);
        chk("s5_clr_wf", wf_a, 0);
        chk("s5_clr_hod", od_h, 0);
        cyc(1, 0, 1, 8'd8);
        chk("s5_after_ov", ov_a, 1);
        chk("s5_after_od", od_a, 2);
        chk("s5_after_hov", ov_h, 0);

        // enable stall and input gaps
        cyc(1, 1, 0, 0);
        cyc(1, 0, 1, 8'd4);
        chk("s6_first_ov", ov_a, 1);
        chk("s6_first_od", od_a, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 8'd99);
            chk($sformatf("s6_stall_ov_%0d", i), ov_a, 0);
            chk($sformatf("s6_stall_od_%0d", i), od_a, 1);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 0, 8'd0);
            chk($sformatf("s6_gap_ov_%0d", i), ov_a, 0);
            chk($sformatf("s6_gap_od_%0d", i), od_a, 1);
        end
        cyc(1, 0, 1, 8'd8);
        chk("s6_last_ov", ov_a, 1);
        chk("s6_last_od", od_a, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
